demux_feeder: RTL and testbench

Upstream sequencer for the 1:4 demultiplexer. Accepts a 4-bit parallel word plus a 4-bit channel mask over a valid/ready handshake. Serialises the word onto the demultiplexer's single data input: it drives `in` and `sel` for each enabled channel in ascending channel order, holding each channel for a programmable number of cycles. It skips masked channels, pulses `done` when the word is finished, and then accepts the next word.

---
 rtl/demux_feeder_pkg.sv | 22 ++
 rtl/demux_feeder_next_set_bit.sv | 39 +++
 rtl/demux_feeder.sv | 132 +++++++++++++
 tb/tb_demux_feeder.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/demux_feeder_pkg.sv
// ============================================================================
// Module      : demux_feeder_pkg
// Description : Shared types and constants for the demux_feeder block.
//               FSM state encoding, channel count and channel index width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package demux_feeder_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : demux_feeder_pkg

`default_nettype wire

// File: rtl/demux_feeder_next_set_bit.sv
// ============================================================================
// Module      : demux_feeder_next_set_bit
// Description : Combinational priority finder. Returns the lowest set bit of
//               i_mask strictly above i_start, or the lowest set bit overall
//               when i_from_zero is asserted.
// Ports       : i_mask      - channel mask to search
//               i_start     - current channel index (search starts above it)
//               i_from_zero - ignore i_start and search from channel 0
//               o_found     - a qualifying bit exists
//               o_idx       - index of that bit (0 when none found)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_feeder_next_set_bit
    import demux_feeder_pkg::*;
(
    input  logic [NUM_CH-1:0] i_mask,
    input  logic [CH_W-1:0]   i_start,
    input  logic              i_from_zero,
    output logic              o_found,
    output logic [CH_W-1:0]   o_idx
);

    // Scan from the top down so the lowest qualifying bit is written last.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (i_mask[k] && (i_from_zero || (k > int'(i_start)))) begin
                o_found = 1'b1;
                o_idx   = CH_W'(k);
            end
        end
    end

endmodule : demux_feeder_next_set_bit

`default_nettype wire

// File: rtl/demux_feeder.sv
// ============================================================================
// Module      : demux_feeder
// Description : Upstream sequencer for a 1:4 demultiplexer. Accepts a 4-bit
//               word plus channel mask over valid/ready and serialises each
//               enabled channel, in ascending order, onto sel/in for
//               HOLD_CYCLES cycles. Pulses done once the word is issued.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               din_valid/din_ready - input handshake
//               din, mask           - data word and channel enable mask
//               sel, in, strobe     - demultiplexer drive, strobe marks live
//               busy                - word in progress (state != IDLE)
//               done                - one-cycle end-of-word pulse
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_feeder
    import demux_feeder_pkg::*;
#(
    parameter int HOLD_CYCLES = 1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [NUM_CH-1:0] din,
    input  logic [NUM_CH-1:0] mask,
    output logic [CH_W-1:0]   sel,
    output logic              in,
    output logic              strobe,
    output logic              busy,
    output logic              done
);

    localparam logic [7:0] c_HOLD_RELOAD = 8'(HOLD_CYCLES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NUM_CH-1:0] r_data;
    logic [NUM_CH-1:0] w_data_nxt;
    logic [NUM_CH-1:0] r_mask;
    logic [NUM_CH-1:0] w_mask_nxt;
    logic [7:0]        r_hold;
    logic [7:0]        w_hold_nxt;
    logic [CH_W-1:0]   r_cur;
    logic [CH_W-1:0]   w_cur_nxt;

    logic [NUM_CH-1:0] w_srch_mask;
    logic              w_from_zero;
    logic              w_found;
    logic [CH_W-1:0]   w_idx;

    // In IDLE the finder looks at the incoming mask from channel 0; in SCAN
    // it looks at the captured mask strictly above the current channel, so
    // the current channel's own bit never affects the result.
    assign w_from_zero = (r_state == IDLE);
    assign w_srch_mask = (r_state == IDLE) ? mask : r_mask;

    demux_feeder_next_set_bit u_next_set_bit (
        .i_mask      (w_srch_mask),
        .i_start     (r_cur),
        .i_from_zero (w_from_zero),
        .o_found     (w_found),
        .o_idx       (w_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_mask  <= '0;
            r_hold  <= '0;
            r_cur   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_mask  <= w_mask_nxt;
            r_hold  <= w_hold_nxt;
            r_cur   <= w_cur_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_mask_nxt  = r_mask;
        w_hold_nxt  = r_hold;
        w_cur_nxt   = r_cur;
        case (r_state)
            IDLE: begin
                if (din_valid) begin
                    w_data_nxt = din;
                    w_mask_nxt = mask;
                    w_hold_nxt = c_HOLD_RELOAD;
                    if (w_found) begin
                        w_cur_nxt   = w_idx;
                        w_state_nxt = SCAN;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            SCAN: begin
                if (r_hold != 8'd0) begin
                    w_hold_nxt = r_hold - 8'd1;
                end else begin
                    w_mask_nxt[r_cur] = 1'b0;
                    if (w_found) begin
                        w_cur_nxt  = w_idx;
                        w_hold_nxt = c_HOLD_RELOAD;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are pure decodes of registered state.
    assign din_ready = (r_state == IDLE);
    assign strobe    = (r_state == SCAN);
    assign sel       = (r_state == SCAN) ? r_cur : '0;
    assign in        = (r_state == SCAN) ? r_data[r_cur] : 1'b0;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);

endmodule : demux_feeder

`default_nettype wire

// File: tb/tb_demux_feeder.sv
// ============================================================================
// Module      : tb_demux_feeder
// Description : Directed self-checking bench for demux_feeder. One instance
//               with HOLD_CYCLES=1 and one with HOLD_CYCLES=3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux_feeder;

    logic       clk;
    logic       rst;

    logic       v1, v3;
    logic [3:0] d1, d3, m1, m3;
    logic       rdy1, rdy3, in1, in3, stb1, stb3, busy1, busy3, done1, done3;
    logic [1:0] sel1, sel3;

    int total;
    int bad;

    demux_feeder #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .din_valid(v1), .din_ready(rdy1),
        .din(d1), .mask(m1), .sel(sel1), .in(in1), .strobe(stb1),
        .busy(busy1), .done(done1)
    );

    demux_feeder #(.HOLD_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .din_valid(v3), .din_ready(rdy3),
        .din(d3), .mask(m3), .sel(sel3), .in(in3), .strobe(stb3),
        .busy(busy3), .done(done3)
    );

    // Observed output bundle: {ready, strobe, sel[1:0], in, busy, done}
    wire [6:0] w_o1 = {rdy1, stb1, sel1, in1, busy1, done1};
    wire [6:0] w_o3 = {rdy3, stb3, sel3, in3, busy3, done3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] mk(input logic r, input logic s,
                                      input logic [1:0] sl, input logic i,
                                      input logic b, input logic d);
        return {r, s, sl, i, b, d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed={rdy,stb,sel,in,busy,done}=%b expected=%b", tag, obs, exp);
        end
    endtask

    localparam logic [6:0] c_IDLE = 7'b1000000;

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        v1 = 1'b0; d1 = 4'h0; m1 = 4'h0;
        v3 = 1'b0; d3 = 4'h0; m3 = 4'h0;

        // Reset held for three cycles
        step(); step(); step();
        chk("reset dut1", w_o1, c_IDLE);
        chk("reset dut3", w_o3, c_IDLE);
        rst = 1'b0;

        // Full word, HOLD=1: din=1010 mask=1111
        v1 = 1'b1; d1 = 4'b1010; m1 = 4'b1111;
        chk("full idle before", w_o1, c_IDLE);
        step(); v1 = 1'b0;
        chk("full ch0", w_o1, mk(0, 1, 2'd0, 0, 1, 0));
        step(); chk("full ch1", w_o1, mk(0, 1, 2'd1, 1, 1, 0));
        step(); chk("full ch2", w_o1, mk(0, 1, 2'd2, 0, 1, 0));
        step(); chk("full ch3", w_o1, mk(0, 1, 2'd3, 1, 1, 0));
        step(); chk("full done", w_o1, mk(0, 0, 2'd0, 0, 1, 1));
        step(); chk("full ready", w_o1, c_IDLE);

        // Sparse mask, HOLD=3: din=1111 mask=1001
        v3 = 1'b1; d3 = 4'b1111; m3 = 4'b1001;
        step(); v3 = 1'b0;
        chk("sparse ch0 c0", w_o3, mk(0, 1, 2'd0, 1, 1, 0));
        step(); chk("sparse ch0 c1", w_o3, mk(0, 1, 2'd0, 1, 1, 0));
        step(); chk("sparse ch0 c2", w_o3, mk(0, 1, 2'd0, 1, 1, 0));
        step(); chk("sparse ch3 c0", w_o3, mk(0, 1, 2'd3, 1, 1, 0));
        step(); chk("sparse ch3 c1", w_o3, mk(0, 1, 2'd3, 1, 1, 0));
        step(); chk("sparse ch3 c2", w_o3, mk(0, 1, 2'd3, 1, 1, 0));
        step(); chk("sparse done", w_o3, mk(0, 0, 2'd0, 0, 1, 1));
        step(); chk("sparse ready", w_o3, c_IDLE);

        // Empty mask: straight to DONE, two cycles total
        v1 = 1'b1; d1 = 4'b1111; m1 = 4'b0000;
        step(); v1 = 1'b0;
        chk("empty done", w_o1, mk(0, 0, 2'd0, 0, 1, 1));
        step(); chk("empty ready", w_o1, c_IDLE);

        // Backpressure: word 0101/0110, then valid held with a new word
        v1 = 1'b1; d1 = 4'b0101; m1 = 4'b0110;
        step();
        chk("bp ch1", w_o1, mk(0, 1, 2'd1, 0, 1, 0));
        d1 = 4'b1010; m1 = 4'b1111;
        step(); chk("bp ch2 keeps word", w_o1, mk(0, 1, 2'd2, 1, 1, 0));
        step(); chk("bp done", w_o1, mk(0, 0, 2'd0, 0, 1, 1));
        step(); chk("bp idle", w_o1, c_IDLE);
        step(); v1 = 1'b0;
        chk("bp w2 ch0", w_o1, mk(0, 1, 2'd0, 0, 1, 0));
        step(); chk("bp w2 ch1", w_o1, mk(0, 1, 2'd1, 1, 1, 0));
        step(); chk("bp w2 ch2", w_o1, mk(0, 1, 2'd2, 0, 1, 0));
        step(); chk("bp w2 ch3", w_o1, mk(0, 1, 2'd3, 1, 1, 0));
        step(); chk("bp w2 done", w_o1, mk(0, 0, 2'd0, 0, 1, 1));
        step(); chk("bp w2 ready", w_o1, c_IDLE);

        // Reset mid-SCAN at channel 2
        v1 = 1'b1; d1 = 4'b1111; m1 = 4'b1111;
        step(); v1 = 1'b0;
        chk("rst ch0", w_o1, mk(0, 1, 2'd0, 1, 1, 0));
        step(); step();
        chk("rst ch2", w_o1, mk(0, 1, 2'd2, 1, 1, 0));
        rst = 1'b1;
        step(); rst = 1'b0;
        chk("rst abort idle", w_o1, c_IDLE);
        step(); chk("rst no done", w_o1, c_IDLE);

        // Back-to-back with valid held, mask=0100
        v1 = 1'b1; d1 = 4'b0100; m1 = 4'b0100;
        step();
        chk("b2b w1 ch2", w_o1, mk(0, 1, 2'd2, 1, 1, 0));
        d1 = 4'b0000;
        step(); chk("b2b w1 done", w_o1, mk(0, 0, 2'd0, 0, 1, 1));
        step(); chk("b2b idle", w_o1, c_IDLE);
        step(); v1 = 1'b0;
        chk("b2b w2 ch2", w_o1, mk(0, 1, 2'd2, 0, 1, 0));
        step(); chk("b2b w2 done", w_o1, mk(0, 0, 2'd0, 0, 1, 1));
        step(); chk("b2b w2 ready", w_o1, c_IDLE);
        step(); chk("b2b no extra", w_o1, c_IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_demux_feeder

`default_nettype wire
